// File: rtl/ctrl_req_sched.sv
// ctrl_req_sched: shares the class-request control block between two
// requesters (0 = USB setup stage, 1 = local configuration).
//
// Handshake: reqN_ready is combinational and high only while idle, for the
// granted requester, and only while reqN_valid is high. A request transfers
// on the rising edge where valid && ready. The requester holds valid, setup
// and params stable until that edge and may change them freely afterwards.
// Each accepted request ends with a single-cycle reqN_done, with reqN_err and
// reqN_rdata updated on the same edge and held until that requester's next done.
module ctrl_req_sched #(
  parameter int START_TO = 16,
  parameter int RUN_TO   = 1024,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [63:0] req0_setup,
  input  logic [31:0] req0_param32,
  input  logic [63:0] req0_param64,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  output logic [63:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [63:0] req1_setup,
  input  logic [31:0] req1_param32,
  input  logic [63:0] req1_param64,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic [63:0] req1_rdata,
  output logic        ctl_enable,
  output logic [63:0] ctl_data,
  output logic [31:0] ctl_param32,
  output logic [63:0] ctl_param64,
  input  logic        ctl_busy,
  input  logic [15:0] ctl_out16,
  input  logic [31:0] ctl_out32,
  input  logic [63:0] ctl_out64,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_RUN       = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             last_grant;
  logic             cur_id;
  logic             grant;
  logic             accept;
  logic [7:0]       sel_type;
  logic             enable_d;
  logic             finish;
  logic             fin_err;
  logic             fin_id;
  logic [63:0]      fin_rdata;
  logic [63:0]      resp_data;

  assign dbg_state = state;

  // Round-robin arbitration and the combinational ready outputs
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
    accept     = rst && (state == S_IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    sel_type   = grant ? req1_setup[63:56] : req0_setup[63:56];
  end

  // Width-selected response from the latched setup word (direction, wLength)
  always_comb begin
    resp_data = '0;
    if (ctl_data[63]) begin
      if (ctl_data[15:0] <= 16'd2)      resp_data = {48'h0, ctl_out16};
      else if (ctl_data[15:0] <= 16'd4) resp_data = {32'h0, ctl_out32};
      else                              resp_data = ctl_out64;
    end
  end

  // Next-state logic, timeout counting and completion decode
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    enable_d  = ctl_enable;
    finish    = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    fin_id    = (state == S_IDLE) ? grant : cur_id;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (sel_type[6:5] != 2'b01) begin
            // Not a class request: reject without touching the control block
            state_d = S_DONE;
            finish  = 1'b1;
            fin_err = 1'b1;
          end else begin
            enable_d = 1'b1;
            state_d  = S_WAIT_BUSY;
          end
        end
      end
      S_WAIT_BUSY: begin
        if (ctl_busy) begin
          enable_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else if (cnt == CNT_W'(START_TO - 1)) begin
          enable_d = 1'b0;
          finish   = 1'b1;
          fin_err  = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!ctl_busy) begin
          finish    = 1'b1;
          fin_rdata = resp_data;
          state_d   = S_DONE;
        end else if (cnt == CNT_W'(RUN_TO - 1)) begin
          finish  = 1'b1;
          fin_err = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched request, and per-requester registered completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      ctl_enable  <= 1'b0;
      ctl_data    <= '0;
      ctl_param32 <= '0;
      ctl_param64 <= '0;
      req0_done   <= 1'b0;
      req0_err    <= 1'b0;
      req0_rdata  <= '0;
      req1_done   <= 1'b0;
      req1_err    <= 1'b0;
      req1_rdata  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ctl_enable <= enable_d;
      req0_done  <= finish && !fin_id;
      req1_done  <= finish && fin_id;
      if (accept) begin
        ctl_data    <= grant ? req1_setup   : req0_setup;
        ctl_param32 <= grant ? req1_param32 : req0_param32;
        ctl_param64 <= grant ? req1_param64 : req0_param64;
        last_grant  <= grant;
        cur_id      <= grant;
      end
      if (finish && !fin_id) begin
        req0_err   <= fin_err;
        req0_rdata <= fin_rdata;
      end
      if (finish && fin_id) begin
        req1_err   <= fin_err;
        req1_rdata <= fin_rdata;
      end
    end
  end

endmodule

// File: doc/ctrl_req_sched.md
Name: ctrl_req_sched

Overview:
- Schedules and shares the class-request control block (enable/busy handshake, 64-bit setup word, 32/64-bit parameter blocks, 16/32/64-bit data outputs) between two requesters.
- Requester 0 is the USB setup-stage path; requester 1 is the local configuration path.
- Arbitrates round-robin, validates the request, drives the control block, supervises busy with timeouts and returns a width-selected response.

Parameters:
START_TO, 16, max cycles ctl_enable is held waiting for ctl_busy to rise
RUN_TO, 1024, max cycles ctl_busy may stay high
CNT_W, 16, timeout counter width; must hold max(START_TO, RUN_TO)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active low
req0_valid  in  1  requester 0 request pending
req0_setup  in  64  {bmRequestType[63:56], bRequest[55:48], wValue[47:32], wIndex[31:16], wLength[15:0]}
req0_param32  in  32  parameter block 32
req0_param64  in  64  parameter block 64
req0_ready  out  1  request accepted this cycle
req0_done  out  1  one-cycle completion pulse
req0_err  out  1  completion status, valid with done
req0_rdata  out  64  response data, valid with done
req1_*  same set as req0_*, for requester 1
ctl_enable  out  1  enable to control block
ctl_data  out  64  setup word to control block
ctl_param32  out  32  parameter block 32 to control block
ctl_param64  out  64  parameter block 64 to control block
ctl_busy  in  1  control block busy
ctl_out16  in  16  control block response, 16-bit
ctl_out32  in  32  control block response, 32-bit
ctl_out64  in  64  control block response, 64-bit

Behaviour:
- Reset (rst=0 at an edge): state IDLE; all outputs 0; last_grant=1, so req0 wins the first tie; timeout counter 0. No done pulse is issued for an aborted transfer. Reset overrides every state.
- FSM states: IDLE, WAIT_BUSY, RUN, DONE.
- IDLE: grant = sole valid requester. If both are valid, grant the one != last_grant.
  - reqN_ready = (state==IDLE && reqN_valid && grant==N). This is combinational, and ready is only ever high for one requester.
  - On the accepting edge: latch setup and params into ctl_data/ctl_param32/ctl_param64; last_grant<=N; cnt<=0.
  - If bmRequestType[6:5] != 2'b01 (not a class request): next state DONE with err=1, and ctl_enable never rises.
  - Otherwise ctl_enable<=1 and next state WAIT_BUSY.
- WAIT_BUSY: ctl_enable held 1; cnt increments each cycle.
  - ctl_busy=1 sampled: ctl_enable<=0, cnt<=0, next state RUN.
  - cnt==START_TO-1 without busy: ctl_enable<=0, err=1, next state DONE.
- RUN: ctl_enable 0; cnt increments.
  - ctl_busy=0 sampled: capture the response, err=0, next state DONE.
  - cnt==RUN_TO-1: err=1, rdata=0, next state DONE.
- Response selection at RUN exit:
  - bmRequestType[7]=0 (host-to-device): rdata=0.
  - Else wLength<=2: rdata = zero-extended ctl_out16.
  - Else wLength<=4: rdata = zero-extended ctl_out32.
  - Else: rdata = ctl_out64.
  - wLength=0 with direction IN: rdata=ctl_out16, zero-extended.
- DONE: exactly one cycle.
  - reqN_done=1 for the granted requester only; reqN_err and reqN_rdata are registered with it and held until that requester's next done.
  - Next state IDLE. A new request can be accepted in the cycle after DONE, so back-to-back service has a one-cycle gap.
- ctl_data and ctl_param* hold the last latched values while idle.
- Valid dropped before ready: nothing is latched and the requester loses nothing; arbitration is re-evaluated each IDLE cycle.
- Requesters hold valid/setup/params stable until ready. Post-accept changes are ignored.

Test Plan:
- req0 setup=0x2103_0000_0000_0002, param32=1. Bus model raises busy 3 cycles after enable and holds it 4 cycles. Required: ctl_enable high exactly until busy is seen; req0_done pulses 1 cycle, err=0, rdata=0; ctl_param32=1.
- req1 setup=0xA183_0000_0000_0002, ctl_out16=0x1234 -> req1_rdata=0x0000_0000_0000_1234, err=0. Repeat with wLength=8 and ctl_out64=0xDEAD_BEEF_0123_4567 -> rdata equals that value.
- Both valid continuously for 4 transfers -> grant order req0, req1, req0, req1; ready never high for both at once.
- req0 setup=0x8006_0100_0000_0012 (standard GET_DESCRIPTOR) -> ctl_enable stays 0; req0_done 1 cycle after accept with err=1.
- Busy never rises -> ctl_enable high for 16 cycles, then done with err=1. Busy stuck high -> done err=1 after 1024 cycles in RUN.
- rst=0 for 1 cycle mid-RUN -> all outputs 0 next cycle, no done pulse; next req0 request after rst=1 is served normally.
